// File: rtl/sensor_init_pkg.sv
// rtl/sensor_init_pkg.sv - shared types, widths and defaults for the sensor init sequencer
package sensor_init_pkg;

    localparam int ROM_AW = 9;

    localparam int DEF_TABLE_LEN      = 512;
    localparam int DEF_STARTUP_CYCLES = 1000000;
    localparam int DEF_SETTLE_CYCLES  = 16;
    localparam int DEF_MAX_RETRY      = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWRUP,
        S_ROM_REQ,
        S_ROM_WAIT,
        S_ISSUE,
        S_WAIT_DONE,
        S_SETTLE,
        S_DONE,
        S_FAIL
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    // Bits needed to hold n-1 (a down-count loaded with n-1), never less than one.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int STARTUP_W = cnt_width(DEF_STARTUP_CYCLES);
    localparam int SETTLE_W  = cnt_width(DEF_SETTLE_CYCLES);
    localparam int RETRY_W   = cnt_width(DEF_MAX_RETRY + 1);

endpackage

// File: rtl/init_delay_timer.sv
// rtl/init_delay_timer.sv - loadable down-counter with a one-cycle expiry pulse
module init_delay_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;
    logic         running;

    // Loading n-1 yields an expiry on the n-th cycle after the load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= load_val;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign expired = running && (count == '0);

endmodule

// File: rtl/sensor_init_sequencer.sv
// rtl/sensor_init_sequencer.sv - walks the sensor init pROM and issues one register write per word
module sensor_init_sequencer
    import sensor_init_pkg::*;
#(
    parameter int TABLE_LEN      = DEF_TABLE_LEN,
    parameter int STARTUP_CYCLES = DEF_STARTUP_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_ad,
    output logic              rom_ce,
    output logic              rom_oce,
    input  logic [15:0]       rom_dout,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [7:0]        wr_reg,
    output logic [7:0]        wr_data,
    input  logic              wr_done,
    input  logic              wr_nack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] err_index
);

    localparam int TW = (cnt_width(STARTUP_CYCLES) > cnt_width(SETTLE_CYCLES)) ?
                        cnt_width(STARTUP_CYCLES) : cnt_width(SETTLE_CYCLES);
    localparam int RW = cnt_width(MAX_RETRY + 1);

    localparam logic [TW-1:0]     PWRUP_LOAD  = TW'(STARTUP_CYCLES - 1);
    localparam logic [TW-1:0]     SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0]     RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [ROM_AW-1:0] LAST_INDEX  = ROM_AW'(TABLE_LEN - 1);

    state_t            state, state_nx;
    logic [ROM_AW-1:0] index;
    logic [RW-1:0]     retry_cnt;
    cmd_t              cmd_q;
    logic              nack_q;

    logic          load_timer, tmr_expired;
    logic [TW-1:0] load_val;
    logic          restart, advance, retry, capture, latch_nack, set_err;

    init_delay_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_timer),
        .load_val (load_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        load_timer = 1'b0;
        load_val   = SETTLE_LOAD;
        restart    = 1'b0;
        advance    = 1'b0;
        retry      = 1'b0;
        capture    = 1'b0;
        latch_nack = 1'b0;
        set_err    = 1'b0;
        rom_ce     = (state == S_ROM_REQ);
        wr_valid   = (state == S_ISSUE);
        done       = (state == S_DONE);
        error      = (state == S_FAIL);
        busy       = !(state == S_IDLE || state == S_DONE || state == S_FAIL);

        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    restart    = 1'b1;
                    load_timer = 1'b1;
                    load_val   = PWRUP_LOAD;
                    state_nx   = S_PWRUP;
                end
            end
            S_PWRUP:    if (tmr_expired) state_nx = S_ROM_REQ;
            S_ROM_REQ:  state_nx = S_ROM_WAIT;
            S_ROM_WAIT: begin
                capture  = 1'b1;
                state_nx = S_ISSUE;
            end
            S_ISSUE:    if (wr_ready) state_nx = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (wr_done) begin
                    latch_nack = 1'b1;
                    load_timer = 1'b1;
                    state_nx   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (tmr_expired) begin
                    if (!nack_q) begin
                        if (index == LAST_INDEX) begin
                            state_nx = S_DONE;
                        end else begin
                            advance  = 1'b1;
                            state_nx = S_ROM_REQ;
                        end
                    end else if (retry_cnt < RETRY_LIMIT) begin
                        // Re-issue the captured word; the ROM is not read again.
                        retry    = 1'b1;
                        state_nx = S_ISSUE;
                    end else begin
                        set_err  = 1'b1;
                        state_nx = S_FAIL;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index     <= '0;
            retry_cnt <= '0;
            cmd_q     <= '0;
            nack_q    <= 1'b0;
            err_index <= '0;
        end else begin
            if (restart) begin
                index     <= '0;
                retry_cnt <= '0;
                err_index <= '0;
            end
            if (advance) begin
                index     <= index + 1'b1;
                retry_cnt <= '0;
            end
            if (retry)      retry_cnt <= retry_cnt + 1'b1;
            if (capture)    cmd_q     <= cmd_t'(rom_dout);
            if (latch_nack) nack_q    <= wr_nack;
            if (set_err)    err_index <= index;
        end
    end

    assign rom_ad  = index;
    assign rom_oce = 1'b1;
    assign wr_reg  = cmd_q.addr;
    assign wr_data = cmd_q.data;

endmodule
